// File: rtl/des_out_serializer_if.sv
// Byte-stream bundle between the DES top level, the output serializer and the transmit path.
// master: drives load/data_out/out_ready; slave: the serializer.
interface des_out_serializer_if;
    logic        load;
    logic [63:0] data_out;
    logic        out_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_last;
    logic        busy;
    logic        overrun;

    modport master (
        output load,
        output data_out,
        output out_ready,
        input  byte_out,
        input  byte_valid,
        input  byte_last,
        input  busy,
        input  overrun
    );

    modport slave (
        input  load,
        input  data_out,
        input  out_ready,
        output byte_out,
        output byte_valid,
        output byte_last,
        output busy,
        output overrun
    );
endinterface

// File: rtl/des_out_serializer.sv
// Captures DES data_out LATENCY cycles after each load into a 2-entry block buffer, then streams bytes.
// Build option: define DES_SER_LSB_FIRST_EN to emit each block LSB byte first (default MSB first).
module des_out_serializer #(
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    des_out_serializer_if.slave  bus
);
    genvar gi;

    logic [LATENCY-1:0] token_reg;
    logic [LATENCY-1:0] token_next;
    logic [63:0]        mem_reg [0:1];
    logic               wr_ptr_reg;
    logic               wr_ptr_next;
    logic               rd_ptr_reg;
    logic               rd_ptr_next;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic [2:0]         idx_reg;
    logic [2:0]         idx_next;
    logic               overrun_reg;
    logic               overrun_next;

    logic               capture;
    logic               valid;
    logic               xfer;
    logic               pop;
    logic               push;
    logic [63:0]        head;
    logic [7:0]         lane [0:7];

    // One token per launched block; the top bit marks the edge where data_out is ready.
    assign token_next[0] = bus.load;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_token
            assign token_next[gi] = token_reg[gi-1];
        end
    endgenerate

    assign capture = token_reg[LATENCY-1];
    assign valid   = (count_reg != 2'd0);
    assign xfer    = valid && bus.out_ready;
    assign pop     = xfer && (idx_reg == 3'd7);
    // A pop on the same edge frees the slot, so a full buffer can still accept.
    assign push    = capture && ((count_reg != 2'd2) || pop);
    assign head    = mem_reg[rd_ptr_reg];

    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
`ifdef DES_SER_LSB_FIRST_EN
            assign lane[gi] = head[8*gi +: 8];
`else
            assign lane[gi] = head[63-8*gi -: 8];
`endif
        end
    endgenerate

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        idx_next     = idx_reg;
        overrun_next = overrun_reg;

        if (push) begin
            wr_ptr_next = ~wr_ptr_reg;
        end
        if (pop) begin
            rd_ptr_next = ~rd_ptr_reg;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        // 3-bit index wraps 7 -> 0 exactly when the head is popped.
        if (xfer) begin
            idx_next = idx_reg + 3'd1;
        end
        if (capture && !push) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            token_reg   <= '0;
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            idx_reg     <= 3'd0;
            overrun_reg <= 1'b0;
        end else begin
            token_reg   <= token_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            idx_reg     <= idx_next;
            overrun_reg <= overrun_next;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= bus.data_out;
        end
    end

    assign bus.byte_valid = valid;
    assign bus.byte_last  = valid && (idx_reg == 3'd7);
    assign bus.byte_out   = valid ? lane[idx_reg] : 8'h00;
    assign bus.busy       = (|token_reg) || valid;
    assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_des_out_serializer.sv
// Scoreboard bench for des_out_serializer: a block-queue reference model predicts bytes, a monitor checks them.
// Honours DES_SER_LSB_FIRST_EN for the expected byte order.
module tb_des_out_serializer;
    localparam int          LAT = 2;
    localparam logic [63:0] KAT = 64'h85E813540F0AB405;

    logic clk = 1'b0;
    logic reset = 1'b0;

    des_out_serializer_if bus();

    des_out_serializer #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [63:0] m_blocks[$];
    int          m_due[$];
    int          m_idx = 0;
    int          edge_no = 0;
    logic        m_overrun = 1'b0;
    logic [7:0]  sent_q[$];
    int          xfer_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_byte = 8'h00;
    logic [63:0] kat_seq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] blk_byte(input logic [63:0] blk, input int k);
        logic [63:0] t;
`ifdef DES_SER_LSB_FIRST_EN
        t = blk >> (8 * k);
`else
        t = blk >> (8 * (7 - k));
`endif
        return t[7:0];
    endfunction

    // Reference model: post-edge state is checked, then advanced for the coming edge.
    always @(negedge clk) begin
        edge_no++;
        if (!reset) begin
            m_blocks.delete();
            m_due.delete();
            exp_q.delete();
            m_idx = 0;
            m_overrun = 1'b0;
        end else begin
            check("byte_valid", bus.byte_valid, m_blocks.size() != 0);
            check("busy", bus.busy, (m_blocks.size() != 0) || (m_due.size() != 0));
            check("overrun", bus.overrun, m_overrun);
            if (m_blocks.size() != 0 && bus.out_ready) begin
                m_idx++;
                if (m_idx == 8) begin
                    m_idx = 0;
                    void'(m_blocks.pop_front());
                end
            end
            if (bus.load) m_due.push_back(edge_no + LAT);
            if (m_due.size() != 0 && m_due[0] == edge_no) begin
                void'(m_due.pop_front());
                if (m_blocks.size() < 2) begin
                    m_blocks.push_back(bus.data_out);
                    for (int k = 0; k < 8; k++) begin
                        exp_t e;
                        e.b = blk_byte(bus.data_out, k);
                        e.last = (k == 7);
                        exp_q.push_back(e);
                    end
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard front.
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_byte", bus.byte_out, prev_byte);
                check("hold_valid", bus.byte_valid, 1'b1);
            end
            if (bus.byte_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid actual=1 required=0 byte=%0h t=%0t", bus.byte_out, $time);
                end else begin
                    check("byte_out", bus.byte_out, exp_q[0].b);
                    check("byte_last", bus.byte_last, exp_q[0].last);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
                if (bus.out_ready) begin
                    sent_q.push_back(bus.byte_out);
                    xfer_cnt++;
                end
            end else begin
                check("idle_last", bus.byte_last, 1'b0);
            end
            prev_hold = bus.byte_valid && !bus.out_ready;
            prev_byte = bus.byte_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n >= budget, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_byte_out"}, bus.byte_out, 8'h00);
        check({name, "_valid"}, bus.byte_valid, 1'b0);
        check({name, "_last"}, bus.byte_last, 1'b0);
        check({name, "_busy"}, bus.busy, 1'b0);
        check({name, "_overrun"}, bus.overrun, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic check_kat(input string name);
        check({name, "_count"}, sent_q.size(), 8);
        for (int i = 0; i < 8 && i < sent_q.size(); i++)
            check({name, "_byte"}, sent_q[i], kat_seq[63-8*i -: 8]);
    endtask

    initial begin
`ifdef DES_SER_LSB_FIRST_EN
        kat_seq = 64'h05B40A0F5413E885;
`else
        kat_seq = KAT;
`endif
        bus.load = 1'b0;
        bus.data_out = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("init");
        reset = 1'b1;
        tick();

        // Known-answer block, downstream always ready
        bus.data_out = KAT;
        bus.out_ready = 1'b1;
        sent_q.delete();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        wait_idle("kat", 100);
        check_kat("kat");
        check("kat_busy_after", bus.busy, 1'b0);
        $display("txn kat: %0d bytes sent", sent_q.size());

        // Same block with alternating backpressure
        sent_q.delete();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int n = 0; n < 100 && (bus.busy || exp_q.size() != 0); n++) begin
            bus.out_ready = ~bus.out_ready;
            tick();
        end
        wait_idle("bp", 20);
        check_kat("bp");
        $display("txn backpressure: %0d bytes sent", sent_q.size());

        // Three loads while stalled: third block must be dropped
        bus.out_ready = 1'b0;
        sent_q.delete();
        for (int k = 0; k < 3; k++) begin
            bus.load = 1'b1;
            bus.data_out = {$urandom, $urandom};
            tick();
        end
        bus.load = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            bus.data_out = {$urandom, $urandom};
            tick();
        end
        check("ovf_overrun", bus.overrun, 1'b1);
        check("ovf_sent_while_stalled", sent_q.size(), 0);
        bus.out_ready = 1'b1;
        wait_idle("ovf", 100);
        check("ovf_count", sent_q.size(), 16);
        check("ovf_sticky", bus.overrun, 1'b1);
        $display("txn overflow: %0d bytes sent overrun=%0b", sent_q.size(), bus.overrun);
        do_reset();

        // Capture lands on the byte-7 pop of a full buffer
        bus.out_ready = 1'b1;
        sent_q.delete();
        for (int k = 0; k < 10; k++) begin
            bus.load = (k == 0 || k == 1 || k == 8);
            bus.data_out = {$urandom, $urandom};
            tick();
        end
        bus.load = 1'b0;
        wait_idle("simul", 100);
        check("simul_overrun", bus.overrun, 1'b0);
        check("simul_count", sent_q.size(), 24);
        $display("txn simultaneous: %0d bytes sent overrun=%0b", sent_q.size(), bus.overrun);

        // Reset after three bytes of a block, then a fresh block
        begin
            int base;
            int n;
            base = xfer_cnt;
            n = 0;
            bus.data_out = KAT;
            bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            while (xfer_cnt - base < 3 && n < 50) begin
                tick();
                n++;
            end
            check("midrst_timeout", n >= 50, 1'b0);
            do_reset();
            sent_q.delete();
            bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            wait_idle("midrst", 100);
            check_kat("midrst");
            $display("txn reset_mid_block: %0d fresh bytes sent", sent_q.size());
        end

        // Random traffic against the model
        do_reset();
        sent_q.delete();
        for (int k = 0; k < 3000; k++) begin
            bus.load = ($urandom % 5) == 0;
            bus.data_out = {$urandom, $urandom};
            bus.out_ready = ($urandom % 4) != 0;
            tick();
        end
        bus.load = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle("rand", 200);
        check("rand_drained", exp_q.size(), 0);
        $display("txn random: %0d bytes sent overrun=%0b", sent_q.size(), bus.overrun);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/des_out_serializer.md
# des_out_serializer

Downstream output stage for the DES core. It watches the same `load` strobe that starts an encryption and, after a fixed pipeline latency, captures the core's 64-bit `data_out` into a two-entry block buffer. It then streams each block out as eight bytes over a valid/ready byte interface. It sits between the DES top level and the byte-wide transmit path, with no feedback into the core.

## Interface
- `LATENCY`, default 2: cycles from the clock edge that samples `load` high to the edge at which `data_out` is captured; range 1..8.
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-low. Clears all state immediately on assertion; release is synchronous to `clk`.
- `load`  in  1: same strobe driven into the DES core; each sampled-high cycle launches one block.
- `data_out`  in  64: ciphertext from the DES core.
- `out_ready`  in  1: downstream can accept a byte this cycle.
- `byte_out`  out  8: current byte. Reset value 8'h00.
- `byte_valid`  out  1: `byte_out` is valid. Reset value 0.
- `byte_last`  out  1: the current byte is byte 7 of its block; qualified by `byte_valid`. Reset value 0.
- `busy`  out  1: a launch is in flight or the buffer is non-empty. Reset value 0.
- `overrun`  out  1: sticky flag, set when a capture is due but the buffer is full. Reset value 0.

## Operation
- **Launch tracking:** a `LATENCY`-bit token shift register. Bit 0 takes `load` each cycle; each bit shifts up every cycle. Back-to-back loads are tracked independently, up to one per cycle.
- **Capture:** when the top token bit is 1, `data_out` is written at that edge into the 2-entry FIFO (`wr_ptr`, `rd_ptr`, 2-bit `count`).
- **Serialization:** the head block is emitted MSB byte first. Byte index `idx` runs 0..7, and `byte_out` = head[63-8*idx -: 8].
  - `byte_valid` = (`count` != 0).
  - `byte_last` = `byte_valid` && (`idx` == 7).
- **Handshake:** a byte transfers on any edge where `byte_valid` && `out_ready`.
  - On transfer, `idx` increments.
  - When `idx` == 7, `idx` wraps to 0 and the head block is popped.
  - `byte_out` is held stable while `byte_valid` && !`out_ready`.
- **Simultaneous capture and pop with FIFO full:** the pop frees a slot on the same edge, so the capture succeeds, `count` stays 2 and `overrun` is not set.
- **Capture while full with no pop:** the block is dropped, `overrun` goes to 1 and stays there until reset, and the FIFO contents are untouched.
- **Reset mid-operation:** in-flight tokens are discarded, the FIFO is emptied, `idx` returns to 0, and all outputs return to their reset values. A block whose bytes were partially sent is abandoned.
- `busy` = (token register != 0) || (`count` != 0).

## Timing
- For `load` sampled at edge N:
  - the block is captured at edge N+`LATENCY`;
  - `byte_valid` rises after edge N+`LATENCY`;
  - the first byte can transfer at edge N+`LATENCY`+1.
- With `out_ready` held high, one block takes 8 consecutive transfer cycles, and there is no bubble between blocks when the next block is already buffered.
- Sustained throughput is one block per 8 cycles. Loads issued faster than that overrun once the two buffer entries fill.
- All outputs are registered or decoded from registers only. There is no combinational path from `out_ready` or `data_out` to any output.

## Configuration
- `DES_SER_LSB_FIRST_EN`
  - Defined: blocks are serialized LSB byte first, `byte_out` = head[8*idx +: 8]; `byte_last` still marks the 8th byte.
  - Undefined (default): MSB byte first, as described above.
  - No other behaviour changes.

## Test plan
- **Known-answer vector:** key 64'h133457799BBCDFF1 and data 64'h0123456789ABCDEF, one load pulse, `out_ready`=1 → bytes 85,E8,13,54,0F,0A,B4,05 on 8 consecutive cycles starting at edge N+3, with `byte_last` on 05 and `busy` low afterwards.
- **Backpressure:** same vector with `out_ready` toggling 1,0,1,0… → the same 8 bytes in order, each held stable while not ready, and no duplicate or lost bytes.
- **Overflow:** three loads on consecutive cycles with `out_ready`=0 → `count`=2, the third block is dropped and `overrun`=1. Then raising `out_ready` → exactly 16 bytes, comprising blocks 1 and 2.
- **Simultaneous pop and capture:** FIFO full with the capture edge aligned to a byte-7 transfer → no overrun, and the new block is emitted after the remaining buffered block.
- **Reset mid-block:** assert `reset` low after 3 bytes have transferred → all outputs 0 immediately. After release, a new load yields a full fresh 8-byte block.
- **Macro build:** with `DES_SER_LSB_FIRST_EN` defined, the known-answer vector → bytes 05,B4,0A,0F,54,13,E8,85.
